// File: rtl/muestreador_sensores.sv
// Sensor sampler: prescaled tick sampling, two-sample debounce, change-only
// publication with a one-cycle Dato_listo pulse gated by the controller state.
module muestreador_sensores #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned THRESH   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sensor,
  input  logic [1:0]       Estados,
  output logic             Dato_listo,
  output logic             Peligro,
  output logic [WIDTH-1:0] dato,
  output logic             ocupado,
  output logic [7:0]       descartes
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] ESPERA   = 2'd0;
  localparam logic [1:0] CONFIRMA = 2'd1;
  localparam logic [1:0] EMITE    = 2'd2;
  localparam logic [1:0] RETIENE  = 2'd3;

  // Controller encodings seen on Estados
  localparam logic [1:0] EST_LEER    = 2'b01;
  localparam logic [1:0] EST_DECIDIR = 2'b10;
  localparam logic [1:0] EST_ALERTA  = 2'b11;

  logic [CW-1:0]    cnt;
  logic             tick;
  logic [1:0]       state;
  logic [WIDTH-1:0] muestra;
  logic             valido;
  logic             receptivo;
  logic             ocupado_tick;

  assign tick         = (cnt == CW'(PRESCALE - 1));
  assign receptivo    = (Estados == EST_LEER) || (Estados == EST_ALERTA);
  assign ocupado_tick = tick && ((state == EMITE) || (state == RETIENE));
  assign ocupado      = (state != ESPERA);

  // Free-running prescaler; independent of the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Overrun counter: ticks that arrive while a word is pending are lost
  always_ff @(posedge clk) begin
    if (rst) begin
      descartes <= '0;
    end else if (ocupado_tick && (descartes != 8'hFF)) begin
      descartes <= descartes + 8'd1;
    end
  end

  // Sample/debounce/publish FSM; Dato_listo defaults low so the pulse lasts one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ESPERA;
      muestra    <= '0;
      valido     <= 1'b0;
      dato       <= '0;
      Peligro    <= 1'b0;
      Dato_listo <= 1'b0;
    end else begin
      Dato_listo <= 1'b0;
      case (state)
        ESPERA: begin
          if (tick) begin
            muestra <= sensor;
            state   <= CONFIRMA;
          end
        end
        CONFIRMA: begin
          if (tick) begin
            if (sensor != muestra) begin
              muestra <= sensor;
            end else if (!valido || (muestra != dato)) begin
              state <= EMITE;
            end else begin
              state <= ESPERA;
            end
          end
        end
        EMITE: begin
          if (receptivo) begin
            Dato_listo <= 1'b1;
            dato       <= muestra;
            Peligro    <= (muestra >= WIDTH'(THRESH));
            valido     <= 1'b1;
            state      <= RETIENE;
          end
        end
        default: begin
          if (Estados == EST_DECIDIR) begin
            state <= ESPERA;
          end
        end
      endcase
    end
  end

endmodule
